// File: rtl/pipelined_addsub_if.sv
// Handshake bundle for pipelined_addsub: operand side (in_*) and result side (out_*).
// The design takes the slave modport and the operand producer/result consumer takes the master.
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Carry-pipelined adder/subtractor: STAGES slices of WIDTH/STAGES bits, LSB slice first,
// with a global stall (adv). WIDTH must be a multiple of STAGES.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic               clk,
    input logic               rst_n,
    pipelined_addsub_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    // Stage k inputs; sa words hold finished sum bits below slice k and raw A bits from slice k up.
    logic [WIDTH-1:0]  sa_in  [STAGES];
    logic [WIDTH-1:0]  bx_in  [STAGES];
    logic [STAGES-1:0] cy_in;
    logic [STAGES-1:0] vld_in;

    logic [WIDTH-1:0]  sa_d   [STAGES];
    logic [STAGES-1:0] cy_d;
    logic              ovf_d;

    logic [WIDTH-1:0]  sa_q   [STAGES];
    logic [WIDTH-1:0]  bx_q   [STAGES];
    logic [STAGES-1:0] cy_q;
    logic [STAGES-1:0] vld_q;
    logic              ovf_q;

    logic              adv;
    logic              unused_bx;

    assign adv       = bus.out_ready || !vld_q[STAGES-1];
    assign unused_bx = ^bx_q[STAGES-1];

    always_comb begin
        sa_in     = '{default: '0};
        bx_in     = '{default: '0};
        cy_in     = '0;
        vld_in    = '0;
        sa_in[0]  = bus.a;
        bx_in[0]  = bus.b ^ {WIDTH{bus.sub}};
        cy_in[0]  = bus.cin ^ bus.sub;
        vld_in[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            sa_in[k]  = sa_q[k-1];
            bx_in[k]  = bx_q[k-1];
            cy_in[k]  = cy_q[k-1];
            vld_in[k] = vld_q[k-1];
        end
    end

    always_comb begin
        logic [SW:0] t;
        t     = '0;
        sa_d  = '{default: '0};
        cy_d  = '0;
        ovf_d = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            t = {1'b0, sa_in[k][k*SW +: SW]} + {1'b0, bx_in[k][k*SW +: SW]}
              + {{SW{1'b0}}, cy_in[k]};
            sa_d[k]              = sa_in[k];
            sa_d[k][k*SW +: SW]  = t[SW-1:0];
            cy_d[k]              = t[SW];
            // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
            if (k == STAGES - 1) begin
                ovf_d = t[SW] ^ (t[SW-1] ^ sa_in[k][WIDTH-1] ^ bx_in[k][WIDTH-1]);
            end
        end
    end

    // ---- stage registers: control and result words ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            sa_q  <= '{default: '0};
        end else if (adv) begin
            vld_q <= vld_in;
            cy_q  <= cy_d;
            ovf_q <= ovf_d;
            sa_q  <= sa_d;
        end
    end

    // ---- stage registers: delayed B operand (no reset needed) ----
    always_ff @(posedge clk) begin
        if (adv) begin
            bx_q <= bx_in;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = sa_q[STAGES-1];
    assign bus.cout      = cy_q[STAGES-1];
    assign bus.ovf       = ovf_q;
endmodule
